// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core front end.
//   XLEN / ILEN      : address and instruction widths
//   PC_INCR          : sequential fetch stride
//   DEFAULT_RESET_PC : default fetch address after reset
//   fetch_entry_t    : {instr, pc} pair carried from fetch to decode
package core_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] PC_INCR          = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries sitting between instruction memory
// and decode.
//   clk, reset  : clock, synchronous active-high reset
//   push, data  : write an entry (taken when not full, or full with a pop)
//   pop         : remove the head entry (ignored when empty)
//   clear       : discard all entries; wins over push and pop
//   head        : current head entry (valid when !empty)
//   count       : number of stored entries, 0..DEPTH
//   empty, full : occupancy flags
module fetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       clear,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    fetch_entry_t  slot_q [DEPTH];

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));
    assign count = count_reg;

    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Entries live in flops rather than RAM so that an entry written on one
    // edge is already the visible head in the following cycle.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            fetch_entry_t slot_reg;

            always_ff @(posedge clk) begin
                if (do_push && !clear && !reset && (wr_ptr_reg == AW'(gi))) begin
                    slot_reg <= push_data;
                end
            end

            assign slot_q[gi] = slot_reg;
        end
    endgenerate

    assign head = slot_q[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !clear && full && !pop));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end of the RV32I pipeline.
//   clk, reset          : clock, synchronous active-high reset
//   imem_req_*          : in-order fetch requests (valid/ready), addr == pc
//   imem_rsp_*          : in-order responses, always accepted
//   redirect_valid/_pc  : branch/jump redirect from EX, flushes fetch state
//   id_valid/_ready     : handshake towards decode
//   id_instr, id_pc     : head instruction and its PC
//   pc                  : current fetch PC
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [ILEN-1:0]  imem_rsp_data,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [ILEN-1:0]  id_instr,
    output logic [XLEN-1:0]  id_pc,
    output logic [XLEN-1:0]  pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(DEPTH);

    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] rsp_pc_reg, rsp_pc_next;
    logic [CW-1:0]   outstanding_reg, outstanding_next;
    logic [CW-1:0]   drop_cnt_reg, drop_cnt_next;

    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_full;
    fetch_entry_t    fifo_head;
    fetch_entry_t    fifo_in;

    logic [CW:0]     credit_used;
    logic            req_fire;
    logic            rsp_keep;

    // Every request in flight and every buffered entry holds one credit, so a
    // returning response always finds a free FIFO slot.
    assign credit_used    = {1'b0, outstanding_reg} + {1'b0, fifo_count};
    assign imem_req_valid = !reset && !redirect_valid && (credit_used < CREDIT_LIMIT);
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses belonging to fetches issued before a redirect are counted off
    // by drop_cnt; only younger responses are kept.
    assign rsp_keep = imem_rsp_valid && !redirect_valid && (drop_cnt_reg == '0);

    assign imem_req_addr = pc_reg;
    assign pc            = pc_reg;

    assign id_valid = !reset && !fifo_empty;
    assign id_instr = fifo_head.instr;
    assign id_pc    = fifo_head.pc;

    assign fifo_in = '{instr: imem_rsp_data, pc: rsp_pc_reg};

    always_comb begin
        pc_next          = pc_reg;
        rsp_pc_next      = rsp_pc_reg;
        outstanding_next = outstanding_reg;
        drop_cnt_next    = drop_cnt_reg;

        if (redirect_valid) begin
            pc_next          = redirect_pc;
            rsp_pc_next      = redirect_pc;
            outstanding_next = outstanding_reg - CW'(imem_rsp_valid);
            // Everything still in flight after this cycle is now stale.
            drop_cnt_next    = outstanding_next;
        end else begin
            if (req_fire) begin
                pc_next = pc_reg + PC_INCR;
            end
            if (rsp_keep) begin
                rsp_pc_next = rsp_pc_reg + PC_INCR;
            end
            outstanding_next = outstanding_reg + CW'(req_fire) - CW'(imem_rsp_valid);
            if (imem_rsp_valid && (drop_cnt_reg != '0)) begin
                drop_cnt_next = drop_cnt_reg - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg          <= RESET_PC;
            rsp_pc_reg      <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
        end else begin
            pc_reg          <= pc_next;
            rsp_pc_reg      <= rsp_pc_next;
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= drop_cnt_next;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rsp_keep),
        .push_data (fifo_in),
        .pop       (id_ready),
        .clear     (redirect_valid),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    a_outstanding_max: assert property (@(posedge clk) disable iff (reset)
        outstanding_reg <= CW'(DEPTH));

    a_drop_within_outstanding: assert property (@(posedge clk) disable iff (reset)
        drop_cnt_reg <= outstanding_reg);

    a_rsp_has_request: assert property (@(posedge clk) disable iff (reset)
        imem_rsp_valid |-> (outstanding_reg != '0));

    a_full_blocks_request: assert property (@(posedge clk) disable iff (reset)
        fifo_full |-> !imem_req_valid);

    a_addr_stable: assert property (@(posedge clk) disable iff (reset)
        (imem_req_valid && !imem_req_ready) |=> (imem_req_addr == $past(imem_req_addr)));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-based model of the fetch
// front end checked every cycle, plus directed literal expectations.
module tb_fetch_unit;
    import core_pkg::*;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .pc             (pc)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: fetches in flight (stale ones marked dead) and buffered entries.
    typedef struct {
        logic [31:0] addr;
        bit          live;
    } flight_t;

    flight_t      m_inflight[$];
    fetch_entry_t m_fifo[$];
    logic [31:0]  m_pc;
    bit           model_on = 1'b0;

    // Instruction memory: in-order, fixed latency, data = addr ^ mem_xor.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_t;

    mem_t         mem_q[$];
    int           mem_lat = 1;
    logic [31:0]  mem_xor = 32'h0;
    int           cyc = 0;

    bit           dut_fire;
    logic [31:0]  fires[$];
    fetch_entry_t pops[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %h, required %h", name, act, exp);
        end
    endtask

    function automatic bit exp_req_valid();
        return !reset && !redirect_valid && ((m_inflight.size() + m_fifo.size()) < DEPTH);
    endfunction

    function automatic bit exp_id_valid();
        return !reset && (m_fifo.size() != 0);
    endfunction

    // Compare process: DUT outputs against the model, every cycle.
    always @(negedge clk) begin
        if (model_on) begin
            chk("req_valid", 32'(imem_req_valid), 32'(exp_req_valid()));
            chk("req_addr", imem_req_addr, m_pc);
            chk("pc", pc, m_pc);
            chk("id_valid", 32'(id_valid), 32'(exp_id_valid()));
            if (exp_id_valid()) begin
                chk("id_pc", id_pc, m_fifo[0].pc);
                chk("id_instr", id_instr, m_fifo[0].instr);
            end
        end
    end

    task automatic model_edge();
        bit      fire;
        flight_t f;
        fire = exp_req_valid() && imem_req_ready;
        if (reset) begin
            m_pc = RST_PC;
            m_inflight.delete();
            m_fifo.delete();
            model_on = 1'b1;
            return;
        end
        if (!redirect_valid && (m_fifo.size() != 0) && id_ready) begin
            void'(m_fifo.pop_front());
        end
        if (imem_rsp_valid && (m_inflight.size() != 0)) begin
            f = m_inflight.pop_front();
            if (f.live && !redirect_valid) begin
                m_fifo.push_back('{instr: imem_rsp_data, pc: f.addr});
            end
        end
        if (redirect_valid) begin
            m_fifo.delete();
            foreach (m_inflight[i]) m_inflight[i].live = 1'b0;
            m_pc = redirect_pc;
        end else if (fire) begin
            m_inflight.push_back('{addr: m_pc, live: 1'b1});
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic mem_drive();
        mem_t m;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if ((mem_q.size() != 0) && (mem_q[0].due <= cyc)) begin
            m = mem_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = m.addr ^ mem_xor;
        end
    endtask

    task automatic tick();
        logic [31:0] fire_addr;
        @(negedge clk);
        dut_fire  = imem_req_valid && imem_req_ready;
        fire_addr = imem_req_addr;
        if (dut_fire) fires.push_back(fire_addr);
        if (id_valid && id_ready && !redirect_valid && !reset) begin
            pops.push_back('{instr: id_instr, pc: id_pc});
        end
        @(posedge clk);
        #1;
        model_edge();
        cyc++;
        if (reset) mem_q.delete();
        else if (dut_fire) mem_q.push_back('{addr: fire_addr, due: cyc + mem_lat - 1});
        mem_drive();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        chk("rst_pc", pc, RST_PC);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        reset = 1'b0;
        fires.delete();
        pops.delete();
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        int k = 0;
        while ((pops.size() < n) && (k < budget)) begin
            tick();
            k++;
        end
        chk(name, 32'(pops.size() >= n), 32'd1);
    endtask

    task automatic wait_fires(input int n, input int budget, input string name);
        int k = 0;
        while ((fires.size() < n) && (k < budget)) begin
            tick();
            k++;
        end
        chk(name, 32'(fires.size() >= n), 32'd1);
    endtask

    logic [15:0] rdy_pat [4];
    logic [15:0] idr_pat [4];
    int          lat_pat [4];

    initial begin
        int k;
        reset          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;

        // Streaming with a 1-cycle memory returning its address.
        mem_lat = 1; mem_xor = 32'h0;
        imem_req_ready = 1'b1; id_ready = 1'b1;
        do_reset(2);
        wait_pops(3, 40, "t1_wait_pops");
        chk("t1_pop0_pc", pops[0].pc, 32'h0);
        chk("t1_pop0_instr", pops[0].instr, 32'h0);
        chk("t1_pop1_pc", pops[1].pc, 32'h4);
        chk("t1_pop2_pc", pops[2].pc, 32'h8);
        chk("t1_pop2_instr", pops[2].instr, 32'h8);
        chk("t1_fire2_addr", fires[2], 32'h8);

        // Decode stalled: credit limit stops fetch after two requests.
        id_ready = 1'b0;
        do_reset(1);
        repeat (8) tick();
        chk("t2_fire_count", 32'(fires.size()), 32'd2);
        chk("t2_fire0", fires[0], 32'h0);
        chk("t2_fire1", fires[1], 32'h4);
        chk("t2_req_valid_low", 32'(imem_req_valid), 32'd0);
        fires.delete();
        id_ready = 1'b1;
        wait_pops(2, 20, "t2_wait_pops");
        chk("t2_pop0_pc", pops[0].pc, 32'h0);
        chk("t2_pop1_pc", pops[1].pc, 32'h4);
        wait_fires(1, 20, "t2_wait_resume");
        chk("t2_resume_addr", fires[0], 32'h8);

        // Memory not ready: address and pc hold.
        mem_xor = 32'h0000_0013;
        imem_req_ready = 1'b0;
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_hold_addr", imem_req_addr, 32'h0);
            chk("t3_hold_pc", pc, 32'h0);
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("t3_pc_after_hs", pc, 32'h4);
        chk("t3_fire_count", 32'(fires.size()), 32'd1);
        repeat (4) tick();

        // Redirect with two fetches outstanding.
        mem_lat = 3;
        imem_req_ready = 1'b1; id_ready = 1'b1;
        do_reset(1);
        tick();
        tick();
        chk("t4_fires_before", 32'(fires.size()), 32'd2);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        chk("t4_no_req_redirect", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        chk("t4_id_valid_after", 32'(id_valid), 32'd0);
        chk("t4_pc_after", pc, 32'h0000_0100);
        fires.delete();
        pops.delete();
        wait_pops(1, 30, "t4_wait_pops");
        chk("t4_first_pc", pops[0].pc, 32'h0000_0100);
        chk("t4_first_instr", pops[0].instr, 32'h0000_0113);
        chk("t4_first_fire", fires[0], 32'h0000_0100);

        // Redirect coinciding with a response while decode is ready.
        mem_lat = 1;
        id_ready = 1'b0;
        do_reset(1);
        k = 0;
        while (!(imem_rsp_valid && id_valid) && (k < 20)) begin
            tick();
            k++;
        end
        chk("t5_setup", 32'(imem_rsp_valid && id_valid), 32'd1);
        pops.delete();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; id_ready = 1'b1;
        chk("t5_no_req_redirect", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        chk("t5_id_valid_after", 32'(id_valid), 32'd0);
        wait_pops(1, 20, "t5_wait_pops");
        chk("t5_first_pc", pops[0].pc, 32'h0000_0200);
        chk("t5_first_instr", pops[0].instr, 32'h0000_0213);

        // PC wrap at the top of the address space, then reset mid-stream.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("t6_pc_top", pc, 32'hFFFF_FFFC);
        fires.delete();
        pops.delete();
        wait_fires(1, 20, "t6_wait_fire");
        chk("t6_fire_top", fires[0], 32'hFFFF_FFFC);
        chk("t6_pc_wrapped", pc, 32'h0);
        wait_pops(2, 20, "t6_wait_pops");
        chk("t6_pop0_pc", pops[0].pc, 32'hFFFF_FFFC);
        chk("t6_pop1_pc", pops[1].pc, 32'h0);
        k = 0;
        dut_fire = 1'b0;
        while (!dut_fire && (k < 10)) begin
            tick();
            k++;
        end
        chk("t6_outstanding_setup", 32'(dut_fire), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_reset_pc", pc, RST_PC);
        chk("t6_reset_id_valid", 32'(id_valid), 32'd0);
        repeat (4) tick();

        // Mixed ready patterns, latencies and back-to-back redirects.
        rdy_pat[0] = 16'hFFFF; rdy_pat[1] = 16'hA5A5; rdy_pat[2] = 16'h0F0F; rdy_pat[3] = 16'hF3CF;
        idr_pat[0] = 16'h5555; idr_pat[1] = 16'hFFFF; idr_pat[2] = 16'hCCCC; idr_pat[3] = 16'h7E7E;
        lat_pat[0] = 1; lat_pat[1] = 2; lat_pat[2] = 3; lat_pat[3] = 1;
        for (int p = 0; p < 4; p++) begin
            mem_lat = lat_pat[p];
            for (int c = 0; c < 48; c++) begin
                imem_req_ready = rdy_pat[p][c % 16];
                id_ready       = idr_pat[p][(c * 3) % 16];
                redirect_valid = (c == 20) || (c == 21) || (c == 37);
                redirect_pc    = 32'h0000_1000 + 32'(p * 256) + ((c == 21) ? 32'h2 : 32'h0);
                tick();
            end
            redirect_valid = 1'b0;
        end
        imem_req_ready = 1'b1; id_ready = 1'b1;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
